am_envelope_detector: RTL
=========================

AM_ENVELOPE_DETECTOR -- requirements
Module: am_envelope_detector

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, ADC sample clock domain; all logic rising-edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port adc_a_stream, input, 8 bits: ADC channel A sample, offset binary (0x80 = mid-scale).
REQ-004 SHALL have port in_valid, input, 1 bit: adc_a_stream valid this cycle.
REQ-005 SHALL have port decim_sel, input, 2 bits: block length N; 0->16, 1->32, 2->64, 3->128.
REQ-006 SHALL have port out_data, output, 8 bits: unsigned envelope estimate, 0..254.
REQ-007 SHALL have port out_valid, output, 1 bit: out_data valid.
REQ-008 SHALL have port out_ready, input, 1 bit: downstream accepts out_data.
REQ-009 SHALL have port overrun, output, 1 bit: sticky; a result was dropped.
REQ-010 SHALL have port clip, output, 1 bit: sticky; a full-scale input (0x00 or 0xFF) was seen.
REQ-011 SHALL have port flags_clr, input, 1 bit: single-cycle clear of overrun and clip.

Function
REQ-012 SHALL register adc_a_stream when in_valid=1 (stage 1) and convert it to two's complement by inverting bit 7.
REQ-013 SHALL compute 7-bit magnitude |x| in stage 2; x=-128 saturates to 127.
REQ-014 SHALL accumulate magnitudes into a 14-bit unsigned accumulator (max 127*128=16256, no overflow).
REQ-015 SHALL count accepted samples; cycles with in_valid=0 advance no pipeline stage and no counter.
REQ-016 SHALL latch decim_sel only at block start (sample count = 0); a change mid-block takes effect on the next block.
REQ-017 SHALL, on the N-th magnitude of a block, form result = (acc + mag) >> log2(N), truncating, 7 bits; then clear acc and count for the next block with no lost sample.
REQ-018 SHALL present out_data = {result, 1'b0}.
REQ-019 SHALL assert out_valid on the 3rd rising edge after the edge capturing the N-th accepted sample, given in_valid held high.
REQ-020 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL deassert out_valid on the edge where out_valid=1 and out_ready=1, unless a new result loads that same edge, in which case out_valid stays 1 with new data.
REQ-022 SHALL, when a new result is ready while out_valid=1 and out_ready=0, drop the new result, keep the held one, and set overrun.
REQ-023 SHALL set clip on any accepted sample equal to 0x00 or 0xFF.
REQ-024 SHALL clear overrun/clip on flags_clr=1, except that a set event in the same cycle wins (flag remains 1).
REQ-025 SHALL operate with in_valid continuously high (one sample per clock) without stalls.

Reset
REQ-026 SHALL, on reset=1 at a clock edge, clear pipeline registers, accumulator, sample count, out_data (0x00), out_valid (0), overrun (0), clip (0).
REQ-027 SHALL discard a partial block on reset mid-operation; the first block after reset starts with the first accepted sample and uses decim_sel sampled then.
REQ-028 SHALL ignore in_valid and out_ready during reset.

Verification
REQ-029 SHALL verify: decim_sel=0, 16 samples of 0xC0, out_ready=1 -> one out_data=0x80, out_valid high one cycle, 3 edges after the 16th sample.
REQ-030 SHALL verify: decim_sel=0, 16 samples of 0x40 -> out_data=0x80; 16 samples of 0x00 -> out_data=0xFE, clip=1.
REQ-031 SHALL verify: out_ready=0, 32 samples of 0xC0 at N=16 -> out_data=0x80 held, overrun=1; flags_clr -> overrun=0.
REQ-032 SHALL verify: decim_sel changed 0->3 after 5 samples -> first block closes at 16 samples, next at 128.
REQ-033 SHALL verify: reset after 10 of 16 samples, then 16 samples of 0x90 -> single out_data=0x20, no result from the partial block.
REQ-034 SHALL verify: in_valid toggled 1/0 every cycle, 16 valid samples of 0xC0 -> out_data=0x80, count advancing only on valid cycles.

Source files
------------

// File: rtl/am_envelope_detector.sv
// AM envelope detector: rectifies offset-binary ADC samples and emits the block mean
// of |x| every N samples through a single-entry valid/ready output register.
module am_envelope_detector (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] adc_a_stream,
    input  logic       in_valid,
    input  logic [1:0] decim_sel,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       overrun,
    output logic       clip,
    input  logic       flags_clr
);

    // Input-side block bookkeeping
    logic [6:0] in_count_reg;
    logic [6:0] in_count_next;
    logic [1:0] sel_reg;
    logic [1:0] cur_sel;
    logic [6:0] last_idx;
    logic       in_last;
    logic [6:0] last_tbl [4];

    // Stage 1: captured two's-complement sample
    logic       s1_valid_reg;
    logic [7:0] s1_data_reg;
    logic       s1_last_reg;
    logic [1:0] s1_sel_reg;

    // Stage 2: magnitude
    logic [7:0] s1_neg;
    logic [6:0] mag_next;
    logic       s2_valid_reg;
    logic [6:0] s2_mag_reg;
    logic       s2_last_reg;
    logic [1:0] s2_sel_reg;

    // Accumulator and block result
    logic [13:0] acc_reg;
    logic [13:0] sum_next;
    logic [13:0] sum_shifted;
    logic [2:0]  shamt;
    logic [6:0]  res_reg;
    logic        res_valid_reg;

    // Output register and flags
    logic [7:0] out_data_reg;
    logic       out_valid_reg;
    logic       overrun_reg;
    logic       clip_reg;
    logic       res_load;
    logic       res_drop;
    logic       clip_set;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_len
            assign last_tbl[gi] = 7'((16 << gi) - 1);
        end
    endgenerate

    // Block length is frozen at the first sample of a block and travels with each sample,
    // so a mid-block decim_sel change only affects the following block.
    always_comb begin
        cur_sel       = (in_count_reg == 7'd0) ? decim_sel : sel_reg;
        last_idx      = last_tbl[cur_sel];
        in_last       = (in_count_reg == last_idx);
        in_count_next = in_last ? 7'd0 : in_count_reg + 7'd1;
        clip_set      = in_valid && ((adc_a_stream == 8'h00) || (adc_a_stream == 8'hFF));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_count_reg <= 7'd0;
            sel_reg      <= 2'd0;
            s1_valid_reg <= 1'b0;
            s1_data_reg  <= 8'd0;
            s1_last_reg  <= 1'b0;
            s1_sel_reg   <= 2'd0;
        end else begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_data_reg  <= {~adc_a_stream[7], adc_a_stream[6:0]};
                s1_last_reg  <= in_last;
                s1_sel_reg   <= cur_sel;
                in_count_reg <= in_count_next;
                sel_reg      <= cur_sel;
            end
        end
    end

    // -128 has no 7-bit magnitude, so it saturates to 127
    always_comb begin
        s1_neg = ~s1_data_reg + 8'd1;
        if (s1_data_reg == 8'h80) begin
            mag_next = 7'd127;
        end else if (s1_data_reg[7]) begin
            mag_next = s1_neg[6:0];
        end else begin
            mag_next = s1_data_reg[6:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_reg <= 1'b0;
            s2_mag_reg   <= 7'd0;
            s2_last_reg  <= 1'b0;
            s2_sel_reg   <= 2'd0;
        end else begin
            s2_valid_reg <= s1_valid_reg;
            if (s1_valid_reg) begin
                s2_mag_reg  <= mag_next;
                s2_last_reg <= s1_last_reg;
                s2_sel_reg  <= s1_sel_reg;
            end
        end
    end

    always_comb begin
        sum_next    = acc_reg + {7'd0, s2_mag_reg};
        shamt       = 3'd4 + {1'b0, s2_sel_reg};
        sum_shifted = sum_next >> shamt;
    end

    // The closing sample folds into the result directly, so the next block starts from zero
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg       <= 14'd0;
            res_reg       <= 7'd0;
            res_valid_reg <= 1'b0;
        end else begin
            res_valid_reg <= 1'b0;
            if (s2_valid_reg) begin
                if (s2_last_reg) begin
                    res_reg       <= sum_shifted[6:0];
                    res_valid_reg <= 1'b1;
                    acc_reg       <= 14'd0;
                end else begin
                    acc_reg <= sum_next;
                end
            end
        end
    end

    always_comb begin
        res_drop = res_valid_reg && out_valid_reg && !out_ready;
        res_load = res_valid_reg && !res_drop;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data_reg  <= 8'd0;
            out_valid_reg <= 1'b0;
            overrun_reg   <= 1'b0;
            clip_reg      <= 1'b0;
        end else begin
            if (res_load) begin
                out_data_reg  <= {res_reg, 1'b0};
                out_valid_reg <= 1'b1;
            end else if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            overrun_reg <= res_drop || (overrun_reg && !flags_clr);
            clip_reg    <= clip_set || (clip_reg && !flags_clr);
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign overrun   = overrun_reg;
    assign clip      = clip_reg;

endmodule
